// File: rtl/add_sub_serial.sv
// add_sub_serial: chunked signed add/subtract with overflow/carry flags, optional accumulate.
// Latency N = LEN/CHUNK cycles from accepted i_start to o_done; one operation in flight.
// No queuing: i_start is ignored while busy. `define ADD_SUB_SAT_EN to clamp o_sum on overflow.
module add_sub_serial #(
  parameter int LEN   = 16,
  parameter int CHUNK = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic           i_sub,
  input  logic           i_acc,
  input  logic [LEN-1:0] i_a,
  input  logic [LEN-1:0] i_b,
  output logic           o_busy,
  output logic           o_done,
  output logic [LEN-1:0] o_sum,
  output logic           o_overflow,
  output logic           o_carry
);

  localparam int N  = LEN / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [LEN-1:0] opa_q, opa_d;
  logic [LEN-1:0] opb_q, opb_d;
  logic [LEN-1:0] res_q, res_d;
  logic           cin_q, cin_d;
  logic           a_msb_q, a_msb_d;
  logic           b_msb_q, b_msb_d;
  logic [LEN-1:0] sum_q, sum_d;
  logic           ovf_q, ovf_d;
  logic           carry_q, carry_d;
  logic           done_q, done_d;

  logic [LEN-1:0] opa_sel;
  logic [LEN-1:0] opb_sel;
  logic [CHUNK:0] chunk_sum;
  logic [LEN-1:0] res_next;
  logic [LEN-1:0] final_sum;
  logic           last;
  logic           ovf_now;

  // Operand A/B as they will be latched on an accepted start (B inverted for subtract).
  assign opa_sel = i_acc ? sum_q : i_a;
  assign opb_sel = i_sub ? ~i_b : i_b;

  // Operands shift right each cycle, so the active chunk is always the low CHUNK bits.
  assign chunk_sum = {1'b0, opa_q[CHUNK-1:0]} + {1'b0, opb_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, cin_q};

  // Result bits enter at the top; after N chunks the full word is aligned.
  assign res_next = (LEN'(chunk_sum[CHUNK-1:0]) << (LEN - CHUNK)) | (res_q >> CHUNK);

  assign last    = (cnt_q == CW'(N - 1));
  assign ovf_now = (a_msb_q == b_msb_q) && (res_next[LEN-1] != a_msb_q);

`ifdef ADD_SUB_SAT_EN
  // Clamp toward the sign of operand A (the true result's sign when overflow occurs).
  assign final_sum = !ovf_now ? res_next :
                     (a_msb_q ? {1'b1, {(LEN-1){1'b0}}} : {1'b0, {(LEN-1){1'b1}}});
`else
  assign final_sum = res_next;
`endif

  // Next-state: accept a start in IDLE, process one chunk per RUN cycle, publish on the last.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cin_d   = cin_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          opa_d   = opa_sel;
          opb_d   = opb_sel;
          res_d   = '0;
          cin_d   = i_sub;
          a_msb_d = opa_sel[LEN-1];
          b_msb_d = opb_sel[LEN-1];
        end
      end
      S_RUN: begin
        opa_d = opa_q >> CHUNK;
        opb_d = opb_q >> CHUNK;
        res_d = res_next;
        cin_d = chunk_sum[CHUNK];
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          sum_d   = final_sum;
          carry_d = chunk_sum[CHUNK];
          ovf_d   = ovf_now;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cin_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cin_q   <= cin_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign o_busy     = (state_q == S_RUN);
  assign o_done     = done_q;
  assign o_sum      = sum_q;
  assign o_overflow = ovf_q;
  assign o_carry    = carry_q;

endmodule

// File: tb/tb_add_sub_serial.sv
// Bench for add_sub_serial: LEN=16/CHUNK=4 and LEN=8/CHUNK=8 instances.
// Drivers push expected results (integer arithmetic model) into queues; monitors pop on o_done.
// Honours ADD_SUB_SAT_EN in the model when the design is built with it.
module tb_add_sub_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ncmp  = 0;
  int nfail = 0;

  typedef struct {
    longint sum;
    bit     ovf;
    bit     cy;
    int     cyc;
  } exp_t;

  exp_t   q16[$];
  exp_t   q8[$];
  exp_t   m16e;
  exp_t   m8e;
  longint msum16 = 0;
  longint msum8  = 0;
  int     nxt16  = 0;
  int     nxt8   = 0;

  logic        rst16_n, s16, sub16, acc16;
  logic [15:0] a16, b16, sum16;
  logic        busy16, done16, ovf16, cy16;

  logic        rst8_n, s8, sub8, acc8;
  logic [7:0]  a8, b8, sum8;
  logic        busy8, done8, ovf8, cy8;

  add_sub_serial #(.LEN(16), .CHUNK(4)) dut16 (
    .i_clk(clk), .i_rst_n(rst16_n), .i_start(s16), .i_sub(sub16), .i_acc(acc16),
    .i_a(a16), .i_b(b16), .o_busy(busy16), .o_done(done16), .o_sum(sum16),
    .o_overflow(ovf16), .o_carry(cy16)
  );

  add_sub_serial #(.LEN(8), .CHUNK(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst8_n), .i_start(s8), .i_sub(sub8), .i_acc(acc8),
    .i_a(a8), .i_b(b8), .o_busy(busy8), .o_done(done8), .o_sum(sum8),
    .o_overflow(ovf8), .o_carry(cy8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    ncmp++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the operand values.
  function automatic void model(input int len, input bit sub, input longint ua, input longint ub,
                                output longint sum, output bit ovf, output bit cy);
    longint m, half, sa, sb, r;
    m    = longint'(1) << len;
    half = m / 2;
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    r    = sub ? sa - sb : sa + sb;
    ovf  = (r >= half) || (r < -half);
    cy   = sub ? (ua >= ub) : (ua + ub >= m);
    sum  = ((r % m) + m) % m;
`ifdef ADD_SUB_SAT_EN
    if (ovf) sum = (r < 0) ? half : half - 1;
`endif
  endfunction

  // Called at a negedge; waits until the DUT will be idle, optionally pulsing junk starts meanwhile.
  task automatic op16(input bit sub, input bit acc, input logic [15:0] a, input logic [15:0] b,
                      input bit junk);
    longint s; bit o, c;
    while (cyc + 1 < nxt16) begin
      s16   = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      a16   = 16'($urandom);
      b16   = 16'($urandom);
      sub16 = 1'($urandom_range(0, 1));
      acc16 = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    s16 = 1'b1; sub16 = sub; acc16 = acc; a16 = a; b16 = b;
    model(16, sub, acc ? msum16 : longint'(a), longint'(b), s, o, c);
    m16e.sum = s; m16e.ovf = o; m16e.cy = c; m16e.cyc = cyc + 1 + 4;
    q16.push_back(m16e);
    msum16 = s;
    nxt16  = cyc + 1 + 4 + 1;
    @(negedge clk);
    s16 = 1'b0;
    chk("busy16_after_start", 64'(busy16), 64'd1);
  endtask

  // Same for the single-chunk instance; junk=1 holds i_start high while busy.
  task automatic op8(input bit sub, input bit acc, input logic [7:0] a, input logic [7:0] b,
                     input bit junk);
    longint s; bit o, c;
    while (cyc + 1 < nxt8) begin
      s8   = junk;
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      sub8 = 1'($urandom_range(0, 1));
      acc8 = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    s8 = 1'b1; sub8 = sub; acc8 = acc; a8 = a; b8 = b;
    model(8, sub, acc ? msum8 : longint'(a), longint'(b), s, o, c);
    m8e.sum = s; m8e.ovf = o; m8e.cy = c; m8e.cyc = cyc + 1 + 1;
    q8.push_back(m8e);
    msum8 = s;
    nxt8  = cyc + 1 + 1 + 1;
    @(negedge clk);
    s8 = junk;
    chk("busy8_after_start", 64'(busy8), 64'd1);
  endtask

  exp_t e16;
  // Monitor for the 16-bit instance.
  always @(negedge clk) begin
    if (done16) begin
      if (q16.size() == 0) begin
        ncmp++; nfail++;
        $display("FAIL done16_unexpected: o_done 1 required 0 (cycle %0d)", cyc);
      end else begin
        e16 = q16.pop_front();
        chk("sum16", 64'(sum16), 64'(e16.sum));
        chk("ovf16", 64'(ovf16), 64'(e16.ovf));
        chk("carry16", 64'(cy16), 64'(e16.cy));
        chk("latency16", 64'(cyc), 64'(e16.cyc));
        chk("busy16_at_done", 64'(busy16), 64'd0);
      end
    end
  end

  exp_t e8;
  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        ncmp++; nfail++;
        $display("FAIL done8_unexpected: o_done 1 required 0 (cycle %0d)", cyc);
      end else begin
        e8 = q8.pop_front();
        chk("sum8", 64'(sum8), 64'(e8.sum));
        chk("ovf8", 64'(ovf8), 64'(e8.ovf));
        chk("carry8", 64'(cy8), 64'(e8.cy));
        chk("latency8", 64'(cyc), 64'(e8.cyc));
        chk("busy8_at_done", 64'(busy8), 64'd0);
      end
    end
  end

  logic [15:0] corner [4];

  initial begin
    corner[0] = 16'h7FFF; corner[1] = 16'h8000; corner[2] = 16'hFFFF; corner[3] = 16'h0001;
    rst16_n = 1'b0; s16 = 1'b0; sub16 = 1'b0; acc16 = 1'b0; a16 = '0; b16 = '0;
    rst8_n  = 1'b0; s8  = 1'b0; sub8  = 1'b0; acc8  = 1'b0; a8  = '0; b8  = '0;
    repeat (3) @(negedge clk);
    chk("rst16_busy", 64'(busy16), 64'd0);
    chk("rst16_done", 64'(done16), 64'd0);
    chk("rst16_sum", 64'(sum16), 64'd0);
    chk("rst16_ovf", 64'(ovf16), 64'd0);
    chk("rst16_carry", 64'(cy16), 64'd0);
    chk("rst8_busy", 64'(busy8), 64'd0);
    chk("rst8_sum", 64'(sum8), 64'd0);
    rst16_n = 1'b1; rst8_n = 1'b1;
    @(negedge clk);

    // Basic add with busy profile over the four chunk cycles.
    op16(1'b0, 1'b0, 16'h1234, 16'h0F0F, 1'b0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("busy16_run", 64'(busy16), 64'd1);
      chk("done16_run", 64'(done16), 64'd0);
    end
    @(negedge clk);
    chk("done16_pulse", 64'(done16), 64'd1);

    // Overflow / carry / borrow boundaries.
    op16(1'b0, 1'b0, 16'h7FFF, 16'h0001, 1'b0);
    op16(1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
    op16(1'b1, 1'b0, 16'h0000, 16'h0001, 1'b0);
    op16(1'b1, 1'b0, 16'h8000, 16'h0001, 1'b0);
    op16(1'b1, 1'b0, 16'h8000, 16'h8000, 1'b0);

    // Accumulate started in the done cycle, with junk start pulses while busy.
    op16(1'b0, 1'b0, 16'h0005, 16'h0003, 1'b0);
    op16(1'b0, 1'b1, 16'($urandom), 16'h0002, 1'b1);

    // Reset in the second RUN cycle aborts the operation.
    op16(1'b0, 1'b0, 16'h0005, 16'h0007, 1'b0);
    @(posedge clk);
    #2;
    rst16_n = 1'b0;
    #1;
    chk("abort16_busy", 64'(busy16), 64'd0);
    chk("abort16_done", 64'(done16), 64'd0);
    chk("abort16_sum", 64'(sum16), 64'd0);
    chk("abort16_ovf", 64'(ovf16), 64'd0);
    chk("abort16_carry", 64'(cy16), 64'd0);
    void'(q16.pop_back());
    msum16 = 0;
    nxt16  = 0;
    repeat (6) @(negedge clk);
    rst16_n = 1'b1;
    op16(1'b0, 1'b0, 16'h0001, 16'h0001, 1'b0);

    // Randomized operations, mixing corners, accumulate and junk starts.
    for (int i = 0; i < 60; i++) begin
      logic [15:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op16(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)));
    end

    // Single-chunk instance: one-cycle latency, then i_start held high continuously.
    op8(1'b0, 1'b0, 8'h7F, 8'h01, 1'b0);
    for (int i = 0; i < 30; i++)
      op8(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b1);
    s8 = 1'b0;

    for (int i = 0; i < 50 && (q16.size() != 0 || q8.size() != 0); i++) @(negedge clk);
    if (q16.size() != 0 || q8.size() != 0) begin
      ncmp++; nfail++;
      $display("FAIL drain: %0d results outstanding required 0", q16.size() + q8.size());
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
